// File: rtl/illness_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// illness_ctrl_pkg
// Shared definitions for the illness treatment sequencer:
//   - state_t       : FSM state encodings (also visible on the top's state port)
//   - res_bundle_t  : request/response bundle, ordered {inc, dec, fast, setval}
//   - pass_through  : regulator-to-resource pass-through rule
// No ports (package).
// -----------------------------------------------------------------------------
package illness_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DOSE     = 2'b01,
    ST_COOLDOWN = 2'b10,
    ST_OVERDOSE = 2'b11
  } state_t;

  // Bit positions inside a {inc, dec, fast, setval} bundle.
  localparam int unsigned BIT_INC    = 3;
  localparam int unsigned BIT_DEC    = 2;
  localparam int unsigned BIT_FAST   = 1;
  localparam int unsigned BIT_SETVAL = 0;

  typedef logic [3:0] res_bundle_t;

  localparam res_bundle_t BUNDLE_NONE     = 4'b0000;
  localparam res_bundle_t BUNDLE_SETVAL   = 4'b0001;
  localparam res_bundle_t BUNDLE_DOSE     = 4'b0110;  // dec + fast
  localparam res_bundle_t BUNDLE_OVERDOSE = 4'b1010;  // inc + fast

  // Regulator pass-through: setval wins outright; conflicting inc/dec cancel
  // each other while fast is still forwarded.
  function automatic res_bundle_t pass_through(input res_bundle_t req);
    res_bundle_t r;
    r = req;
    if (req[BIT_SETVAL]) begin
      r = BUNDLE_SETVAL;
    end else if (req[BIT_INC] && req[BIT_DEC]) begin
      r[BIT_INC] = 1'b0;
      r[BIT_DEC] = 1'b0;
    end else begin
      r = req;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_downcounter.sv
// -----------------------------------------------------------------------------
// tick_downcounter
// Loadable CNT_W-bit down-counter that saturates at zero (never wraps).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears to 0)
//   load        : load load_val (takes precedence over dec)
//   load_val    : value to load
//   dec         : decrement by one when nonzero
//   value       : current count
//   zero        : count is zero
// -----------------------------------------------------------------------------
module tick_downcounter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Count register: load beats decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && !zero) begin
      value <= value - CNT_ONE;
    end else begin
      value <= value;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/illness_treatment_ctrl.sv
// -----------------------------------------------------------------------------
// illness_treatment_ctrl
// Sequencer between the illness regulator and the 9-bit illness resource.
// In IDLE/COOLDOWN, regulator requests pass through on each tick. A medicine
// action while ill starts a timed fast-decrement dose, followed by a cooldown;
// medicine during cooldown is an overdose (timed fast-increment).
//
// Optional build macro: TREATMENT_STATS_EN adds saturating 8-bit dose_count
// and overdose_count outputs.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   tick                     : one-cycle resource update strobe
//   medicine                 : one-cycle medicine action pulse
//   ill                      : current ill flag
//   illness_level[1:0]       : illness[8:7] from the resource
//   reg_inc/dec/fast/setval  : regulator requests
//   res_inc/dec/fast/setval  : registered requests to the resource (1 clk)
//   state[1:0]               : current FSM state
//   overdose                 : high while in OVERDOSE
//   dose_count[7:0]          : (TREATMENT_STATS_EN) IDLE->DOSE entries
//   overdose_count[7:0]      : (TREATMENT_STATS_EN) COOLDOWN->OVERDOSE entries
// -----------------------------------------------------------------------------
module illness_treatment_ctrl
  import illness_ctrl_pkg::*;
#(
  parameter int DOSE_TICKS     = 8,
  parameter int COOLDOWN_TICKS = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       medicine,
  input  logic       ill,
  input  logic [1:0] illness_level,
  input  logic       reg_inc,
  input  logic       reg_dec,
  input  logic       reg_fast,
  input  logic       reg_setval,
  output logic       res_inc,
  output logic       res_dec,
  output logic       res_fast,
  output logic       res_setval,
  output logic [1:0] state,
  output logic       overdose
`ifdef TREATMENT_STATS_EN
  ,
  output logic [7:0] dose_count,
  output logic [7:0] overdose_count
`endif
);

  localparam logic [CNT_W-1:0] DOSE_LOAD     = CNT_W'(DOSE_TICKS);
  localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  state_t           cur_state;
  state_t           next_state;
  res_bundle_t      req;
  res_bundle_t      res_next;
  res_bundle_t      res_q;
  logic             overdose_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             last_tick;

  assign req = {reg_inc, reg_dec, reg_fast, reg_setval};

  // A tick now drives the counter to zero (or it is already there).
  assign last_tick = cnt_zero || (cnt_value == CNT_ONE);

  tick_downcounter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // Next-state, counter control and next resource bundle.
  always_comb begin
    next_state   = cur_state;
    res_next     = BUNDLE_NONE;
    cnt_load     = 1'b0;
    cnt_load_val = DOSE_LOAD;
    cnt_dec      = 1'b0;

    case (cur_state)
      ST_IDLE: begin
        if (tick) begin
          res_next = pass_through(req);
        end else begin
          res_next = BUNDLE_NONE;
        end
        if (medicine && ill) begin
          next_state   = ST_DOSE;
          cnt_load     = 1'b1;
          cnt_load_val = DOSE_LOAD;
        end else begin
          next_state = ST_IDLE;
        end
      end

      ST_DOSE: begin
        if (tick) begin
          res_next = BUNDLE_DOSE;
          cnt_dec  = 1'b1;
          // Early exit when illness is already low; the dec still goes out.
          if (last_tick || (illness_level == 2'b00)) begin
            next_state   = ST_COOLDOWN;
            cnt_load     = 1'b1;
            cnt_load_val = COOLDOWN_LOAD;
          end else begin
            next_state = ST_DOSE;
          end
        end else begin
          next_state = ST_DOSE;
        end
      end

      ST_COOLDOWN: begin
        if (tick) begin
          res_next = pass_through(req);
          cnt_dec  = 1'b1;
        end else begin
          res_next = BUNDLE_NONE;
        end
        // Medicine beats expiry on the same edge.
        if (medicine) begin
          next_state   = ST_OVERDOSE;
          cnt_load     = 1'b1;
          cnt_load_val = DOSE_LOAD;
        end else if (tick && last_tick) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_COOLDOWN;
        end
      end

      ST_OVERDOSE: begin
        if (tick) begin
          res_next = BUNDLE_OVERDOSE;
          cnt_dec  = 1'b1;
          if (last_tick) begin
            next_state   = ST_COOLDOWN;
            cnt_load     = 1'b1;
            cnt_load_val = COOLDOWN_LOAD;
          end else begin
            next_state = ST_OVERDOSE;
          end
        end else begin
          next_state = ST_OVERDOSE;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase

    // setval wins in every state; counter behaviour above is unaffected.
    if (tick && reg_setval) begin
      res_next = BUNDLE_SETVAL;
    end else begin
      res_next = res_next;
    end
  end

  // State, resource outputs and overdose flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= ST_IDLE;
      res_q      <= BUNDLE_NONE;
      overdose_q <= 1'b0;
    end else begin
      cur_state  <= next_state;
      res_q      <= res_next;
      overdose_q <= (next_state == ST_OVERDOSE);
    end
  end

  assign res_inc    = res_q[BIT_INC];
  assign res_dec    = res_q[BIT_DEC];
  assign res_fast   = res_q[BIT_FAST];
  assign res_setval = res_q[BIT_SETVAL];
  assign state      = cur_state;
  assign overdose   = overdose_q;

`ifdef TREATMENT_STATS_EN
  logic [7:0] dose_cnt;
  logic [7:0] od_cnt;

  // Saturating counts of dose and overdose entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dose_cnt <= 8'd0;
      od_cnt   <= 8'd0;
    end else begin
      if ((cur_state == ST_IDLE) && (next_state == ST_DOSE) && (dose_cnt != 8'hFF)) begin
        dose_cnt <= dose_cnt + 8'd1;
      end else begin
        dose_cnt <= dose_cnt;
      end
      if ((cur_state == ST_COOLDOWN) && (next_state == ST_OVERDOSE) && (od_cnt != 8'hFF)) begin
        od_cnt <= od_cnt + 8'd1;
      end else begin
        od_cnt <= od_cnt;
      end
    end
  end

  assign dose_count     = dose_cnt;
  assign overdose_count = od_cnt;
`endif

endmodule

// File: doc/illness_treatment_ctrl.md
Name: illness_treatment_ctrl

Overview:
Sequencer between the illness regulator and the 9-bit illness resource. Passes regulator inc/dec/fast/setval requests through on each update tick. A medicine action overrides them with a timed fast-decrement dose, then enforces a cooldown. A second dose during cooldown is an overdose and drives a timed fast-increment.

Parameters:
DOSE_TICKS, 8, number of ticks a dose or an overdose lasts (1..2^CNT_W-1)
COOLDOWN_TICKS, 16, ticks of cooldown after a dose or overdose (1..2^CNT_W-1)
CNT_W, 5, width of the tick down-counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle resource update strobe
medicine  input  1  one-cycle medicine action pulse
ill  input  1  current ill flag from illness_system
illness_level  input  2  illness[8:7] from resource
reg_inc  input  1  regulator increment request
reg_dec  input  1  regulator decrement request
reg_fast  input  1  regulator fast-step request
reg_setval  input  1  regulator set-to-default request
res_inc  output  1  registered increment to resource
res_dec  output  1  registered decrement to resource
res_fast  output  1  registered fast-step to resource
res_setval  output  1  registered setval to resource
state  output  2  current FSM state
overdose  output  1  high while in OVERDOSE

Behaviour:
- Reset: state=IDLE, counter=0, all res_* = 0, overdose = 0.
- res_* are registered. Latency is 1 clk: a tick at edge N produces outputs valid for exactly one cycle after edge N. With no tick, res_* = 0 next cycle.
- The tick is evaluated against the state held before the edge. A state transition on the same edge affects the next tick only.
- Pass-through (IDLE, COOLDOWN), on tick:
  - res_* = reg_*.
  - If reg_inc and reg_dec are both set, both outputs are 0 and fast is still passed.
- Priority: reg_setval always wins. When set on a tick, res_setval=1 and res_inc/dec/fast=0 in every state. The counter still decrements.
- IDLE:
  - medicine with ill=1: go to DOSE, counter=DOSE_TICKS.
  - medicine with ill=0: ignored.
- DOSE, on tick:
  - res_dec=1, res_fast=1, res_inc=0. Regulator inc/dec/fast are ignored.
  - counter decrements.
  - Exit to COOLDOWN (counter=COOLDOWN_TICKS) when the counter reaches 0, or when illness_level==2'b00 on that tick (early exit, the dec is still emitted).
  - medicine is ignored.
- COOLDOWN, on tick: counter decrements.
  - Counter reaching 0: go to IDLE.
  - medicine (any tick phase, any ill value): go to OVERDOSE, counter=DOSE_TICKS. Medicine on the same edge as expiry takes precedence, so the block goes to OVERDOSE.
- OVERDOSE, on tick:
  - res_inc=1, res_fast=1, res_dec=0.
  - counter decrements. At 0, go to COOLDOWN with counter=COOLDOWN_TICKS.
  - medicine is ignored. overdose=1 in this state.
- The counter saturates at 0 and never wraps.
- Reset mid-dose: immediate return to IDLE, outputs 0, no residual pulse.

Optional Feature:
TREATMENT_STATS_EN:
- Enabled: adds output dose_count[7:0] (reset 0). It increments on each IDLE->DOSE entry and saturates at 255. It also adds output overdose_count[7:0] with the same rule for COOLDOWN->OVERDOSE.
- Disabled: neither port nor their registers exist, and behaviour is otherwise identical.

Decomposition:
- Package illness_ctrl_pkg holds the state encodings: ST_IDLE=2'b00, ST_DOSE=2'b01, ST_COOLDOWN=2'b10, ST_OVERDOSE=2'b11. It also holds the reg-to-res output bundle ordering {inc,dec,fast,setval}.
- One sub-module, tick_downcounter: a CNT_W-bit loadable down-counter with load, value, decrement enable and a zero flag, saturating at 0.

Test Plan:
- Reset then reg_inc=1 on tick: the next cycle shows res_inc=1 for one cycle only. With reg_inc=reg_dec=1: res_inc=res_dec=0.
- ill=1, medicine, then 8 ticks with illness_level=2'b10: exactly 8 one-cycle pulses of res_dec=res_fast=1, then state=COOLDOWN. reg_inc is ignored throughout.
- DOSE with illness_level=2'b00 at the 3rd tick: 3 dec pulses, then COOLDOWN. After 16 further ticks, state=IDLE.
- Medicine at COOLDOWN tick 5: OVERDOSE, overdose=1, 8 ticks of res_inc=res_fast=1, then COOLDOWN reloaded to 16.
- ill=0 medicine in IDLE: state stays IDLE. reg_setval on a DOSE tick: res_setval=1, res_dec=0.
- rst_n low mid-DOSE, asynchronously: all outputs 0 immediately, state=IDLE. With TREATMENT_STATS_EN, 300 dose cycles give dose_count=255.
